prf_wr_arb: RTL and testbench

- Write-port arbiter/scheduler in front of the physical register file.
- Collects result-writeback requests from NUM_REQ execution/load pipes, buffers each in a small per-requester FIFO, and grants up to NUM_REG_WRITES of them per cycle round-robin.
- Drives the PRF write interface (wr_en_nq_ro0 / wr_pkt_ro0), which also clears PRF pend bits.
- Sits between the execute/memory pipes and the prf instances (one arbiter output feeds all prf types; prf filters by pdst.ptype).

---
 rtl/prf_wr_arb.sv | 159 +++++++++++++++
 tb/tb_prf_wr_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prf_wr_arb.sv
// PRF write-port arbiter: per-requester FIFOs feeding
// NUM_REG_WRITES round-robin granted, registered write ports.
package prf_pkg;

  typedef enum logic [1:0] {
    PRF_INT,
    PRF_FP,
    PRF_VEC,
    PRF_RSVD
  } t_prf_type;

  typedef struct packed {
    t_prf_type  ptype;
    logic [6:0] idx;
  } t_prf_id;

  typedef logic [63:0] t_rv_reg_data;

  typedef struct packed {
    t_prf_id      pdst;
    t_rv_reg_data data;
  } t_prf_wr_pkt;

endpackage

module prf_wr_arb
  import prf_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int NUM_REG_WRITES = 1,
  parameter  int FIFO_DEPTH     = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  t_prf_wr_pkt               req_pkt [NUM_REQ],
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REG_WRITES-1:0] wr_en_nq_ro0,
  output t_prf_wr_pkt               wr_pkt_ro0 [NUM_REG_WRITES],
  output logic [CW-1:0]             fifo_cnt [NUM_REQ]
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  t_prf_wr_pkt mem [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0] rptr [NUM_REQ];
  logic [PW-1:0] wptr [NUM_REQ];
  logic [RW-1:0] rr_ptr;
  logic [RW-1:0] rr_nxt;

  logic [NUM_REQ-1:0] ne;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;
  int                 pos  [NUM_REQ];
  int                 rank [NUM_REQ];
  int                 last_pos;
  int                 last_idx;

  logic [NUM_REG_WRITES-1:0] port_vld;
  t_prf_wr_pkt               port_pkt [NUM_REG_WRITES];

  // pos = distance from rr_ptr in scan order;
  // rank = non-empty FIFOs scanned before this one.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ne[i]      = fifo_cnt[i] != '0;
      req_rdy[i] = fifo_cnt[i] != CW'(FIFO_DEPTH);
      push[i]    = req_vld[i] && req_rdy[i];
      pos[i]     = i - int'(rr_ptr);
      if (pos[i] < 0) pos[i] = pos[i] + NUM_REQ;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      rank[i] = 0;
      for (int m = 0; m < NUM_REQ; m++) begin
        if (ne[m] && pos[m] < pos[i]) begin
          rank[i] = rank[i] + 1;
        end
      end
      gnt[i] = ne[i] && (rank[i] < NUM_REG_WRITES);
    end
    port_vld = '0;
    for (int k = 0; k < NUM_REG_WRITES; k++) begin
      port_pkt[k] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && rank[i] == k) begin
          port_vld[k] = 1'b1;
          port_pkt[k] = mem[i][rptr[i]];
        end
      end
    end
    any_gnt  = |gnt;
    last_pos = -1;
    last_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && pos[i] > last_pos) begin
        last_pos = pos[i];
        last_idx = i;
      end
    end
    if (last_idx + 1 == NUM_REQ) rr_nxt = '0;
    else rr_nxt = RW'(last_idx + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      wr_en_nq_ro0 <= '0;
      for (int k = 0; k < NUM_REG_WRITES; k++) begin
        wr_pkt_ro0[k] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        fifo_cnt[i] <= '0;
        rptr[i]     <= '0;
        wptr[i]     <= '0;
      end
    end else begin
      if (any_gnt) rr_ptr <= rr_nxt;
      wr_en_nq_ro0 <= port_vld;
      for (int k = 0; k < NUM_REG_WRITES; k++) begin
        if (port_vld[k]) wr_pkt_ro0[k] <= port_pkt[k];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (gnt[i]) rptr[i] <= rptr[i] + PW'(1);
        fifo_cnt[i] <= fifo_cnt[i] + CW'(push[i])
                       - CW'(gnt[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wptr[i]] <= req_pkt[i];
    end
  end

  a_vld_known: assert property (
    @(posedge clk) disable iff (reset)
    !$isunknown(req_vld));

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_full
    a_no_push_full: assert property (
      @(posedge clk) disable iff (reset)
      !(req_vld[i] && !req_rdy[i]));
  end

  for (genvar a = 0; a < NUM_REG_WRITES; a++) begin : g_pa
    for (genvar b = a + 1; b < NUM_REG_WRITES; b++) begin : g_pb
      a_uniq_pdst: assert property (
        @(posedge clk) disable iff (reset)
        !(wr_en_nq_ro0[a] && wr_en_nq_ro0[b] &&
          wr_pkt_ro0[a].pdst == wr_pkt_ro0[b].pdst));
    end
  end

endmodule

// File: tb/tb_prf_wr_arb.sv
// Bench for prf_wr_arb: one- and two-port instances driven
// with shared packets, checked against a queue-based model.
module tb_prf_wr_arb;
  import prf_pkg::*;

  localparam int NR = 4;
  localparam int FD = 2;
  localparam int CW = $clog2(FD + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0] vld1, vld2, rdy1, rdy2;
  t_prf_wr_pkt   pkt_in [NR];
  logic [0:0]    en1;
  t_prf_wr_pkt   wp1 [1];
  logic [1:0]    en2;
  t_prf_wr_pkt   wp2 [2];
  logic [CW-1:0] cnt1 [NR];
  logic [CW-1:0] cnt2 [NR];

  prf_wr_arb #(
    .NUM_REQ(NR), .NUM_REG_WRITES(1), .FIFO_DEPTH(FD)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .req_vld(vld1), .req_pkt(pkt_in), .req_rdy(rdy1),
    .wr_en_nq_ro0(en1), .wr_pkt_ro0(wp1),
    .fifo_cnt(cnt1)
  );

  prf_wr_arb #(
    .NUM_REQ(NR), .NUM_REG_WRITES(2), .FIFO_DEPTH(FD)
  ) u_dut2 (
    .clk(clk), .reset(reset),
    .req_vld(vld2), .req_pkt(pkt_in), .req_rdy(rdy2),
    .wr_en_nq_ro0(en2), .wr_pkt_ro0(wp2),
    .fifo_cnt(cnt2)
  );

  t_prf_wr_pkt mq [2][NR][$];
  int          rr [2];
  logic [1:0]  xen [2];
  t_prf_wr_pkt xpkt [2][2];
  int          checks = 0;
  int          errors = 0;
  int          seq = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic gen_pkts();
    for (int i = 0; i < NR; i++) begin
      pkt_in[i].pdst.ptype = t_prf_type'(2'($urandom));
      pkt_in[i].pdst.idx   = 7'(seq);
      pkt_in[i].data       = {$urandom, $urandom};
      seq++;
    end
  endtask

  // One clock of the reference: serve up to d+1 non-empty
  // queues in rotating order, then append accepted pushes.
  task automatic model_step(input int d, input bit rst,
                            input logic [NR-1:0] v);
    int n;
    int last;
    if (rst) begin
      for (int i = 0; i < NR; i++) mq[d][i].delete();
      rr[d] = 0;
      xen[d] = '0;
      xpkt[d][0] = '0;
      xpkt[d][1] = '0;
      return;
    end
    n = 0;
    last = -1;
    xen[d] = '0;
    for (int j = 0; j < NR; j++) begin
      int i;
      i = (rr[d] + j) % NR;
      if (n < d + 1 && mq[d][i].size() > 0) begin
        xpkt[d][n] = mq[d][i].pop_front();
        xen[d][n] = 1'b1;
        n++;
        last = i;
      end
    end
    if (last >= 0) rr[d] = (last + 1) % NR;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) mq[d][i].push_back(pkt_in[i]);
    end
  endtask

  task automatic compare_all();
    check("en1", 128'(en1[0]), 128'(xen[0][0]));
    check("pkt1", 128'(wp1[0]), 128'(xpkt[0][0]));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("en2_%0d", k),
            128'(en2[k]), 128'(xen[1][k]));
      check($sformatf("pkt2_%0d", k),
            128'(wp2[k]), 128'(xpkt[1][k]));
    end
    for (int i = 0; i < NR; i++) begin
      check($sformatf("cnt1_%0d", i),
            128'(cnt1[i]), 128'(mq[0][i].size()));
      check($sformatf("rdy1_%0d", i),
            128'(rdy1[i]), 128'(mq[0][i].size() < FD));
      check($sformatf("cnt2_%0d", i),
            128'(cnt2[i]), 128'(mq[1][i].size()));
      check($sformatf("rdy2_%0d", i),
            128'(rdy2[i]), 128'(mq[1][i].size() < FD));
    end
  endtask

  task automatic step(input logic [NR-1:0] want,
                      input bit rst);
    for (int i = 0; i < NR; i++) begin
      vld1[i] = want[i] && (mq[0][i].size() < FD);
      vld2[i] = want[i] && (mq[1][i].size() < FD);
    end
    reset = rst;
    model_step(0, rst, vld1);
    model_step(1, rst, vld2);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    vld1 = '0;
    vld2 = '0;
    gen_pkts();
    model_step(0, 1'b1, '0);
    model_step(1, 1'b1, '0);
    @(negedge clk);
    step('0, 1'b1);
    check("rst_rdy1", 128'(rdy1), 128'(4'hf));
    check("rst_en2", 128'(en2), 128'(0));
    step('0, 1'b0);
    check("post_rst_rdy2", 128'(rdy2), 128'(4'hf));

    // single requester, latency two
    pkt_in[2].pdst.ptype = PRF_INT;
    pkt_in[2].pdst.idx   = 7'd5;
    pkt_in[2].data       = 64'hAA;
    step(4'b0100, 1'b0);
    check("s1_en_t1", 128'(en1), 128'(0));
    gen_pkts();
    step('0, 1'b0);
    check("s1_en_t2", 128'(en1), 128'(1));
    check("s1_idx", 128'(wp1[0].pdst.idx), 128'(5));
    check("s1_data", 128'(wp1[0].data), 128'(64'hAA));
    step('0, 1'b0);
    check("s1_en_t3", 128'(en1), 128'(0));

    // all four at once, one port: order 0,1,2,3
    step('0, 1'b1);
    gen_pkts();
    for (int i = 0; i < NR; i++) pkt_in[i].data = 64'(i);
    step(4'hf, 1'b0);
    for (int t = 0; t < NR; t++) begin
      step('0, 1'b0);
      check($sformatf("s2_en_%0d", t),
            128'(en1), 128'(1));
      check($sformatf("s2_data_%0d", t),
            128'(wp1[0].data), 128'(t));
    end
    step('0, 1'b0);
    check("s2_idle", 128'(en1), 128'(0));

    // backpressure: req 0 and 1 always pushing
    step('0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      gen_pkts();
      step(4'b0011, 1'b0);
      if (c == 1) check("s3_rdy1", 128'(rdy1[1]), 128'(0));
    end

    // reset with packets buffered
    step('0, 1'b1);
    gen_pkts();
    step(4'b0111, 1'b0);
    step('0, 1'b1);
    check("s6_cnt", 128'(cnt2[1]), 128'(0));
    for (int c = 0; c < 3; c++) begin
      step('0, 1'b0);
      check($sformatf("s6_en_%0d", c),
            128'({en2, en1}), 128'(0));
    end

    // random traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      gen_pkts();
      step(4'($urandom), $urandom_range(0, 99) == 0);
    end
    for (int c = 0; c < 8; c++) step('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
